buffer16_bist: RTL

BUFFER16_BIST -- requirements
Module: buffer16_bist

---
 rtl/buffer16_bist.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/buffer16_bist.sv
// buffer16_bist -- built-in self test for a 16-bit buffer-like device.
// A Galois LFSR (mask 16'hB400) drives dut_in. After SETTLE cycles the
// response is compared with dut_in. Mismatches and checked vectors are
// counted. busy follows the SETTLE/CHECK states. done and pass rise one
// cycle after the FSM reaches DONE and clear on the edge that samples a new
// start.
// Optional feature: define BUFFER16_BIST_FAIL_CAPTURE_EN to add fail_valid,
// fail_in and fail_out. These capture the first mismatching vector of a run.
module buffer16_bist #(
  parameter int unsigned NUM_VECTORS = 10000,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned SETTLE      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dut_out,
  output logic [15:0] dut_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] vec_count
`ifdef BUFFER16_BIST_FAIL_CAPTURE_EN
  ,
  output logic        fail_valid,
  output logic [15:0] fail_in,
  output logic [15:0] fail_out
`endif
);

  // An all-zero LFSR state would lock up, so a zero seed becomes 1.
  localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] NUM_VEC_W   = 16'(NUM_VECTORS);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Right-shifting Galois step. It never maps a nonzero state to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    lfsr_next = (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  settle_cnt_r;
  logic [15:0] dut_in_r;
  logic [15:0] err_count_r;
  logic [15:0] vec_count_r;
  logic        busy_r;
  logic        done_r;
  logic        pass_r;

  logic        start_run_s;
  logic        mismatch_s;
  logic [15:0] vec_inc_s;
  logic        last_vec_s;
  logic        busy_s;
  logic        done_s;
  logic        pass_s;

  // Decode run start, compare result and end-of-run from current state.
  always_comb begin
    start_run_s = 1'b0;
    if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      start_run_s = start;
    end else begin
      start_run_s = 1'b0;
    end
    mismatch_s = (dut_out != dut_in_r);
    vec_inc_s  = vec_count_r + 16'd1;
    last_vec_s = (vec_inc_s == NUM_VEC_W);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic. start is not examined in SETTLE or CHECK.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_SETTLE;
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_CHECK: begin
        if (last_vec_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs. busy tracks the state. done/pass lag entry to DONE by one
  // cycle and drop as soon as a new start is taken.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      ST_SETTLE, ST_CHECK: busy_s = 1'b1;
      default:             busy_s = 1'b0;
    endcase
    if ((state_r == ST_DONE) && (state_s == ST_DONE)) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
    pass_s = done_s && (err_count_r == 16'h0000);
  end

  // Register the status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      pass_r <= pass_s;
    end
  end

  // Settle counter. It counts cycles spent in SETTLE and is zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_r <= 4'd0;
    end else if ((state_r == ST_SETTLE) && (state_s == ST_SETTLE)) begin
      settle_cnt_r <= settle_cnt_r + 4'd1;
    end else begin
      settle_cnt_r <= 4'd0;
    end
  end

  // Stimulus register. It loads on start and advances only after a CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in_r <= 16'h0000;
    end else if (start_run_s) begin
      dut_in_r <= SEED_EFF;
    end else if ((state_r == ST_CHECK) && !last_vec_s) begin
      dut_in_r <= lfsr_next(dut_in_r);
    end else begin
      dut_in_r <= dut_in_r;
    end
  end

  // Vector and saturating error counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= 16'h0000;
      vec_count_r <= 16'h0000;
    end else if (start_run_s) begin
      err_count_r <= 16'h0000;
      vec_count_r <= 16'h0000;
    end else if (state_r == ST_CHECK) begin
      vec_count_r <= vec_inc_s;
      if (mismatch_s && (err_count_r != 16'hFFFF)) begin
        err_count_r <= err_count_r + 16'd1;
      end else begin
        err_count_r <= err_count_r;
      end
    end else begin
      err_count_r <= err_count_r;
      vec_count_r <= vec_count_r;
    end
  end

`ifdef BUFFER16_BIST_FAIL_CAPTURE_EN
  logic        fail_valid_r;
  logic [15:0] fail_in_r;
  logic [15:0] fail_out_r;

  // Capture only the first mismatching vector of each run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_r <= 1'b0;
      fail_in_r    <= 16'h0000;
      fail_out_r   <= 16'h0000;
    end else if (start_run_s) begin
      fail_valid_r <= 1'b0;
      fail_in_r    <= 16'h0000;
      fail_out_r   <= 16'h0000;
    end else if ((state_r == ST_CHECK) && mismatch_s && !fail_valid_r) begin
      fail_valid_r <= 1'b1;
      fail_in_r    <= dut_in_r;
      fail_out_r   <= dut_out;
    end else begin
      fail_valid_r <= fail_valid_r;
      fail_in_r    <= fail_in_r;
      fail_out_r   <= fail_out_r;
    end
  end

  assign fail_valid = fail_valid_r;
  assign fail_in    = fail_in_r;
  assign fail_out   = fail_out_r;
`endif

  assign dut_in    = dut_in_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_count_r;
  assign vec_count = vec_count_r;

endmodule
